dehaze_axis_framer: RTL



---
 rtl/dehaze_axis_framer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dehaze_axis_framer.sv
// dehaze_axis_framer
// ------------------
// Output framing stage for the dehaze pipeline. Recovered pixels (J_R, J_G,
// J_B with a valid strobe, no upstream stall) are buffered in a small
// first-word-fall-through FIFO. They are presented as an AXI4-Stream master
// with TUSER marking the first pixel of a frame and TLAST marking the last.
// A pixel that arrives while the FIFO is full and is not being drained is
// dropped. The drop is flagged on a sticky overflow bit.
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   in_valid           recovered pixel strobe (push, cannot be stalled)
//   in_J_R/G/B         recovered pixel channels, 8 bits each
//   M_AXIS_TDATA       {8'h00, R, G, B} of the FIFO head
//   M_AXIS_TVALID      FIFO non-empty
//   M_AXIS_TREADY      downstream ready
//   M_AXIS_TUSER       start of frame (first pixel)
//   M_AXIS_TLAST       end of frame (last pixel)
//   frame_done         one-cycle pulse after the TLAST beat is accepted
//   overflow           sticky, set when a pixel is dropped; cleared by rst
//   fifo_level         FIFO occupancy after the most recent edge
//   frame_state        current frame FSM state (0 = SOF, 1 = STREAM)
//
// Handshake: a beat transfers on every rising edge where TVALID and TREADY
// are both high. TVALID depends only on FIFO occupancy, never on TREADY. It
// falls only after a transfer empties the FIFO. While TVALID is high and
// TREADY is low, TDATA, TUSER and TLAST hold their values, because head,
// counters and FSM change only on a transfer.

module dehaze_axis_framer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_J_R,
  input  logic [7:0]                    in_J_G,
  input  logic [7:0]                    in_J_B,
  output logic [31:0]                   M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic                          M_AXIS_TUSER,
  output logic                          M_AXIS_TLAST,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam bit               ONE_PIX  = (IMG_WIDTH * IMG_HEIGHT == 1);

  typedef enum logic {
    SOF    = 1'b0,
    STREAM = 1'b1
  } state_t;

  logic [23:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  state_t           state;
  state_t           state_nxt;

  logic valid;
  logic pop;
  logic wr_en;
  logic drop;
  logic at_last;
  logic tuser;

  assign valid   = (count != '0);
  assign pop     = valid & M_AXIS_TREADY;
  // A full FIFO still takes the new pixel when the head leaves on the same edge.
  assign wr_en   = in_valid & ((count != DEPTH_C) | pop);
  assign drop    = in_valid & (count == DEPTH_C) & ~pop;
  assign at_last = (col == COL_LAST) & (row == ROW_LAST);

  // Pixel storage. Contents need no reset; only the pointers and count
  // define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_J_R, in_J_G, in_J_B};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame position counters follow accepted beats, not pushes. A dropped
  // pixel therefore shifts framing for the remainder of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row == ROW_LAST) begin
          row <= '0;
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Frame FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SOF;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame FSM: next state and TUSER.
  always_comb begin
    state_nxt = state;
    tuser     = 1'b0;
    case (state)
      SOF: begin
        tuser = valid;
        if (pop && !ONE_PIX) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (pop && at_last) begin
          state_nxt = SOF;
        end
      end
      default: begin
        state_nxt = SOF;
      end
    endcase
  end

  // Status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= pop & at_last;
      overflow   <= overflow | drop;
    end
  end

  // Zero the data bus while empty. TDATA is then clean out of reset,
  // and stale storage never appears on the bus.
  assign M_AXIS_TDATA  = valid ? {8'h00, mem[rd_ptr]} : 32'h0;
  assign M_AXIS_TVALID = valid;
  assign M_AXIS_TUSER  = tuser;
  assign M_AXIS_TLAST  = valid & at_last;
  assign fifo_level    = count;
  assign frame_state   = state;

endmodule
